// File: rtl/bcd_gated_counter_ndigit.sv
// bcd_gated_counter_ndigit
//   N-digit BCD event counter with a measurement gate. While a window is
//   open, every hit strobe adds one to a BCD count. After GATE_CYCLES
//   window cycles the count is copied to bcd_out, valid pulses for one
//   cycle, and the count restarts. Continuous mode opens the next window
//   with no dead cycles in between.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset, overrides every other input
//   en          block enable; dropping it ends an open window with no result
//   start       one-cycle pulse, opens a window when idle
//   continuous  re-open a window automatically after each result
//   hit         one-cycle event strobe, already synchronous to clk
//   bcd_out     latched result, digit k on [4k+3:4k], least significant at k=0
//   valid       one-cycle pulse in the cycle after bcd_out is updated
//   overflow    count overflowed during the latched window (sticky)
//   busy        a window is open

// One BCD digit of the increment chain. Incoming carry adds one;
// carry-out fires when the digit rolls over from 9 to 0.
module bcd_gated_counter_digit (
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  assign cout = cin & (d == 4'd9);

  always_comb begin
    q = d;
    if (cin) q = (d == 4'd9) ? 4'd0 : d + 4'd1;
  end
endmodule

module bcd_gated_counter_ndigit #(
  parameter int NDIGIT      = 8,
  parameter int GATE_CYCLES = 100000000,
  parameter int SATURATE    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  hit,
  output logic [4*NDIGIT-1:0]   bcd_out,
  output logic                  valid,
  output logic                  overflow,
  output logic                  busy
);
  localparam int             TW   = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0]  LAST = TW'(GATE_CYCLES - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  logic [0:0]              state;
  logic [TW-1:0]           timer;
  logic [NDIGIT-1:0][3:0]  cnt, cnt_inc, cnt_nxt, res;
  logic [NDIGIT:0]         carry;
  logic                    wflag, wflag_nxt;

  // Ripple carry through all digits; the constant carry-in of 1 makes
  // cnt_inc = cnt + 1 every cycle, and the final carry-out means cnt was
  // all nines.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NDIGIT; g++) begin : g_dig
    bcd_gated_counter_digit u_dig (
      .d    (cnt[g]),
      .cin  (carry[g]),
      .q    (cnt_inc[g]),
      .cout (carry[g+1])
    );
  end

  // On overflow the increment has already wrapped to all zeros, so the
  // wrapping mode takes cnt_inc as is and the saturating mode keeps cnt.
  always_comb begin
    cnt_nxt   = cnt;
    wflag_nxt = wflag;
    if (hit) begin
      wflag_nxt = wflag | carry[NDIGIT];
      cnt_nxt   = (carry[NDIGIT] && SATURATE != 0) ? cnt : cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      cnt      <= '0;
      wflag    <= 1'b0;
      res      <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // A hit in the start cycle belongs to no window.
          if (start && en) begin
            state <= S_COUNT;
            timer <= '0;
            cnt   <= '0;
            wflag <= 1'b0;
          end
        end
        default: begin
          if (!en) begin
            // Abort: the result registers keep their previous values.
            state <= S_IDLE;
            timer <= '0;
            cnt   <= '0;
            wflag <= 1'b0;
          end else if (timer == LAST) begin
            // Last sampled cycle: its own hit is part of the result.
            res      <= cnt_nxt;
            overflow <= wflag_nxt;
            valid    <= 1'b1;
            timer    <= '0;
            cnt      <= '0;
            wflag    <= 1'b0;
            state    <= continuous ? S_COUNT : S_IDLE;
          end else begin
            cnt   <= cnt_nxt;
            wflag <= wflag_nxt;
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

  assign bcd_out = res;
  assign busy    = (state == S_COUNT);
endmodule

// File: tb/tb_bcd_gated_counter_ndigit.sv
// Directed bench. Four instances cover the parameter sets of interest:
//   a: 3 digits, 10-cycle gate, saturating
//   b: 2 digits, 200-cycle gate, saturating
//   c: 2 digits, 200-cycle gate, wrapping (shares inputs with b)
//   d: 4 digits, 2000-cycle gate, saturating
// Inputs change 1 time unit after a rising edge, and outputs are sampled
// at that same point, so they show the result of that edge.
module tb_bcd_gated_counter_ndigit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a_en, a_start, a_cont, a_hit, a_valid, a_ovf, a_busy;
  logic [11:0] a_bcd;
  logic bc_en, bc_start, bc_cont, bc_hit;
  logic b_valid, b_ovf, b_busy, c_valid, c_ovf, c_busy;
  logic [7:0] b_bcd, c_bcd;
  logic d_en, d_start, d_cont, d_hit, d_valid, d_ovf, d_busy;
  logic [15:0] d_bcd;

  bcd_gated_counter_ndigit #(.NDIGIT(3), .GATE_CYCLES(10), .SATURATE(1)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .start(a_start), .continuous(a_cont),
    .hit(a_hit), .bcd_out(a_bcd), .valid(a_valid), .overflow(a_ovf), .busy(a_busy));
  bcd_gated_counter_ndigit #(.NDIGIT(2), .GATE_CYCLES(200), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .en(bc_en), .start(bc_start), .continuous(bc_cont),
    .hit(bc_hit), .bcd_out(b_bcd), .valid(b_valid), .overflow(b_ovf), .busy(b_busy));
  bcd_gated_counter_ndigit #(.NDIGIT(2), .GATE_CYCLES(200), .SATURATE(0)) dut_c (
    .clk(clk), .rst(rst), .en(bc_en), .start(bc_start), .continuous(bc_cont),
    .hit(bc_hit), .bcd_out(c_bcd), .valid(c_valid), .overflow(c_ovf), .busy(c_busy));
  bcd_gated_counter_ndigit #(.NDIGIT(4), .GATE_CYCLES(2000), .SATURATE(1)) dut_d (
    .clk(clk), .rst(rst), .en(d_en), .start(d_start), .continuous(d_cont),
    .hit(d_hit), .bcd_out(d_bcd), .valid(d_valid), .overflow(d_ovf), .busy(d_busy));

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_en = 0; a_start = 0; a_cont = 0; a_hit = 0;
    bc_en = 0; bc_start = 0; bc_cont = 0; bc_hit = 0;
    d_en = 0; d_start = 0; d_cont = 0; d_hit = 0;

    // ---- reset state
    tick();
    tick();
    chk("rst_bcd",   a_bcd, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_ovf",   a_ovf, 0);
    chk("rst_busy",  a_busy, 0);
    rst = 0;

    // ---- A1: hit held high through the start cycle and all 10 window cycles
    a_en = 1; a_start = 1; a_hit = 1;
    tick();
    chk("a1_busy_open", a_busy, 1);
    a_start = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("a1_valid_early", a_valid, 0);
    chk("a1_busy_mid", a_busy, 1);
    tick();
    chk("a1_valid", a_valid, 1);
    chk("a1_bcd",   a_bcd, 12'h010);
    chk("a1_ovf",   a_ovf, 0);
    chk("a1_busy_fall", a_busy, 0);
    a_hit = 0;
    tick();
    chk("a1_valid_once", a_valid, 0);
    chk("a1_bcd_hold",   a_bcd, 12'h010);
    chk("a1_idle",       a_busy, 0);

    // ---- A2: continuous, hits on window cycles 0, 4, 9, three windows
    a_cont = 1; a_start = 1;
    tick();
    a_start = 0;
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 10; c++) begin
        a_hit = (c == 0 || c == 4 || c == 9);
        if (w == 2 && c == 9) a_cont = 0;
        tick();
        if (c == 9) begin
          chk($sformatf("a2_valid_w%0d", w), a_valid, 1);
          chk($sformatf("a2_bcd_w%0d", w), a_bcd, 12'h003);
          chk($sformatf("a2_busy_w%0d", w), a_busy, (w == 2) ? 1'b0 : 1'b1);
        end else if (c == 5) begin
          chk($sformatf("a2_novalid_w%0d", w), a_valid, 0);
        end
      end
    end
    a_hit = 0;

    // ---- A3: abort at window cycle 5 after 3 hits
    a_start = 1;
    tick();
    a_start = 0;
    for (int c = 0; c < 5; c++) begin
      a_hit = (c < 3);
      tick();
    end
    a_hit = 0; a_en = 0;
    tick();
    chk("a3_abort_valid", a_valid, 0);
    chk("a3_abort_busy",  a_busy, 0);
    chk("a3_abort_bcd",   a_bcd, 12'h003);
    a_start = 1;
    tick();
    chk("a3_start_en0", a_busy, 0);

    // ---- A4: fresh window; start pulse mid-window must not shift the gate
    a_en = 1;
    tick();
    a_start = 0;
    chk("a4_busy_open", a_busy, 1);
    for (int c = 0; c < 10; c++) begin
      a_hit   = (c == 1 || c == 2);
      a_start = (c == 3);
      tick();
      if (c == 8) chk("a4_valid_early", a_valid, 0);
    end
    chk("a4_valid", a_valid, 1);
    chk("a4_bcd",   a_bcd, 12'h002);
    a_hit = 0; a_start = 0;

    // ---- A5: reset mid-window in continuous mode
    a_cont = 1; a_start = 1;
    tick();
    a_start = 0; a_hit = 1;
    for (int c = 0; c < 3; c++) tick();
    rst = 1;
    tick();
    chk("a5_rst_bcd",   a_bcd, 0);
    chk("a5_rst_valid", a_valid, 0);
    chk("a5_rst_busy",  a_busy, 0);
    chk("a5_rst_ovf",   a_ovf, 0);
    rst = 0; a_hit = 0; a_cont = 0;
    tick();
    chk("a5_idle_busy", a_busy, 0);
    a_en = 0;

    // ---- B/C: overflow, saturating vs wrapping, hit every cycle
    bc_en = 1; bc_start = 1; bc_hit = 1;
    tick();
    bc_start = 0;
    for (int i = 0; i < 200; i++) tick();
    chk("b_valid", b_valid, 1);
    chk("b_bcd",   b_bcd, 8'h99);
    chk("b_ovf",   b_ovf, 1);
    chk("c_valid", c_valid, 1);
    chk("c_bcd",   c_bcd, 8'h00);
    chk("c_ovf",   c_ovf, 1);
    bc_hit = 0;
    tick();
    // next window: 5 hits, flag must restart clear
    bc_start = 1;
    tick();
    bc_start = 0;
    for (int c = 0; c < 200; c++) begin
      bc_hit = (c < 5);
      tick();
      if (c == 100) chk("b_ovf_hold", b_ovf, 1);
    end
    chk("b2_bcd", b_bcd, 8'h05);
    chk("b2_ovf", b_ovf, 0);
    chk("c2_bcd", c_bcd, 8'h05);
    chk("c2_ovf", c_ovf, 0);
    bc_hit = 0;

    // ---- D: digit carry 1099 then 1100; idle hits must be ignored
    d_en = 1; d_hit = 1;
    tick(); tick();
    chk("d_idle_busy", d_busy, 0);
    d_start = 1; d_hit = 0;
    tick();
    d_start = 0;
    for (int c = 0; c < 2000; c++) begin
      d_hit = (c < 1099);
      tick();
    end
    chk("d1_valid", d_valid, 1);
    chk("d1_bcd",   d_bcd, 16'h1099);
    chk("d1_ovf",   d_ovf, 0);
    d_start = 1; d_hit = 0;
    tick();
    d_start = 0;
    for (int c = 0; c < 2000; c++) begin
      d_hit = (c < 1100);
      tick();
    end
    chk("d2_valid", d_valid, 1);
    chk("d2_bcd",   d_bcd, 16'h1100);
    d_hit = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_gated_counter_ndigit.md
Name: bcd_gated_counter_ndigit

Overview:
- Parametrised N-digit BCD event counter with a built-in measurement gate: counts single-cycle hit strobes over a programmable window of GATE_CYCLES clocks.
- At window end, latches the count into a held result register with a valid strobe, then clears.
- Successor to the free-running N-digit BCD counter; adds gating, result latching, single-shot/continuous modes, saturation and sticky overflow.
- Sits between the MPPC discriminator pulse synchroniser and the BCD display/readout logic.

Parameters:
- NDIGIT, 8, number of BCD digits (1..16).
- GATE_CYCLES, 100000000, window length in clk cycles (>=2); timer width = clog2(GATE_CYCLES).
- SATURATE, 1, 1 = count holds at all-9s on overflow; 0 = wraps to all-0s.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; low aborts any window.
- start  in  1  one-cycle pulse; begins a window when idle.
- continuous  in  1  1 = re-arm automatically after each window.
- hit  in  1  one-cycle event strobe, already synchronised to clk.
- bcd_out  out  4*NDIGIT  latched result, digit k on bits [4k+3:4k], LS digit at k=0.
- valid  out  1  one-cycle pulse when bcd_out is updated.
- overflow  out  1  sticky overflow for the latched window.
- busy  out  1  high while a window is open.

Behaviour:
- Reset: synchronous, active-high. All state is cleared on the rising clk edge with rst=1: state=IDLE, count=0, timer=0, bcd_out=0, valid=0, overflow=0, busy=0. rst has priority over every other input.
- States: IDLE, COUNT.
- IDLE -> COUNT: on start=1 && en=1. At that edge timer=0 and count=0. A hit in the start cycle is not counted.
- COUNT:
  - Each cycle with hit=1 increments the internal BCD count by 1.
  - Each digit rolls 9->0 and carries into the next digit, same cycle (combinational carry chain).
  - The timer increments every cycle.
- Window length: exactly GATE_CYCLES COUNT cycles are sampled. The final one is the cycle with timer == GATE_CYCLES-1.
- Final-cycle edge:
  - bcd_out <= count + hit, including a hit in that cycle.
  - overflow <= window overflow flag.
  - valid <= 1 for exactly one cycle.
  - count and timer are cleared.
  - Next state: COUNT if continuous=1 && en=1 (sampled at this edge), otherwise IDLE.
  - No dead time between windows in continuous mode.
- Overflow: an increment from all-9s sets the internal window overflow flag.
  - SATURATE=1: count stays at all-9s.
  - SATURATE=0: count wraps to all-0s.
  - The flag is cleared at the start of each window.
  - Output overflow updates only at latch time, together with bcd_out.
- Abort: en=0 in COUNT -> IDLE at next edge. Count, timer and flag are cleared. bcd_out and overflow hold their previous values; no valid pulse.
- start is ignored in COUNT and when en=0.
- busy: high exactly when state=COUNT, registered.
- bcd_out and overflow hold between latches. valid is high only in the cycle after a final-cycle edge.
- Reset mid-window: no valid pulse; bcd_out is cleared to 0.
- Hits while in IDLE are ignored.

Test Plan:
- NDIGIT=3, GATE_CYCLES=10, SATURATE=1; start, hit held high for all 10 window cycles, continuous=0 -> one valid pulse, bcd_out=0x010, overflow=0, busy falls the same cycle valid rises, state IDLE.
- Hits on window cycles 0, 4 and 9 (last), continuous=1, three consecutive windows with identical stimulus -> valid every 10 cycles, bcd_out=0x003 each time, no missing or doubled hits at window boundaries.
- NDIGIT=2, GATE_CYCLES=200, SATURATE=1, hit high every cycle -> bcd_out=0x99, overflow=1. Repeat with SATURATE=0 -> bcd_out=0x00 (200 mod 100), overflow=1. Next window with 5 hits -> bcd_out=0x05, overflow=0.
- Digit carry: NDIGIT=4, 1099 hits in one window (GATE_CYCLES=2000) -> bcd_out=0x1099. With 1100 hits -> bcd_out=0x1100, checking the cascaded carry through two digits.
- Abort: en dropped at window cycle 5 after 3 hits -> no valid, busy=0, bcd_out keeps its prior value. Next start gives a fresh count from 0.
- rst asserted mid-window in continuous mode -> next cycle all outputs 0, state IDLE. start issued while busy has no effect on timer phase.
